// File: rtl/seg7_scan_decoder.sv
// Passive monitor for the multiplexed 7-digit display bus: rebuilds stable per-digit
// segment patterns from the scan, decodes them to hex and tracks scan health.
module seg7_scan_decoder #(
    parameter int          DIGITS       = 7,
    parameter int          SETTLE       = 4,
    parameter int          STABLE_SCANS = 2,
    parameter logic [27:0] TIMEOUT      = 28'd100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS-1:0]   trans,
    input  logic [6:0]          led7seg,
    output logic [7*DIGITS-1:0] seg_out,
    output logic [4*DIGITS-1:0] hex_out,
    output logic [DIGITS-1:0]   hex_valid,
    output logic                frame_stb,
    output logic                scan_active,
    output logic [7:0]          err_cnt
);
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [2:0] STABLE_C = 3'(STABLE_SCANS);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    logic [DIGITS-1:0]   trans_s1_q, trans_s2_q;
    logic [6:0]          led_s1_q, led_s2_q;
    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [2:0]          dig_q, dig_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7*DIGITS-1:0] last_q, last_d, seg_q, seg_d;
    logic [3*DIGITS-1:0] mcnt_q, mcnt_d;
    logic [4*DIGITS-1:0] hex_q, hex_d;
    logic [DIGITS-1:0]   hv_q, hv_d;
    logic [DIGITS-1:0]   seen_q, seen_d, seen_or, samp_bit;
    logic                frame_q, frame_d;
    logic [27:0]         idle_q, idle_d;
    logic                active_q, active_d;
    logic [7:0]          err_q, err_d;
    logic                ill_q, ill_d;

    logic [2:0] zero_cnt, sel_dig;
    logic       sel_onehot, sel_illegal, start, sample;

    function automatic logic [4:0] hex_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h10;
            7'b1111001: return 5'h11;
            7'b0100100: return 5'h12;
            7'b0110000: return 5'h13;
            7'b0011001: return 5'h14;
            7'b0010010: return 5'h15;
            7'b0000010: return 5'h16;
            7'b1111000: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0010000: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b0000011: return 5'h1B;
            7'b1000110: return 5'h1C;
            7'b0100001: return 5'h1D;
            7'b0000110: return 5'h1E;
            7'b0001110: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    // trans[DIGITS-1-i] low selects digit i
    always_comb begin
        zero_cnt = '0;
        sel_dig  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!trans_s2_q[DIGITS-1-i]) begin
                zero_cnt = zero_cnt + 3'd1;
                sel_dig  = 3'(i);
            end
        end
        sel_onehot  = (zero_cnt == 3'd1);
        sel_illegal = (zero_cnt >= 3'd2);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        sel_d   = sel_q;
        start   = 1'b0;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: start = sel_onehot;
            ST_SETTLE: begin
                if (trans_s2_q == sel_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == SETTLE_C) begin
                        sample  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (sel_onehot) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (trans_s2_q != sel_q) begin
                    if (sel_onehot) start = 1'b1;
                    else            state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_SETTLE;
            cnt_d   = 4'd1;
            dig_d   = sel_dig;
            sel_d   = trans_s2_q;
            if (SETTLE_C == 4'd1) begin
                sample  = 1'b1;
                state_d = ST_HOLD;
            end
        end
    end

    // Per-digit stability filter; a pattern is committed only on the scan that reaches STABLE_SCANS
    always_comb begin
        last_d = last_q;
        mcnt_d = mcnt_q;
        seg_d  = seg_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sample && dig_d == 3'(i)) begin
                if (led_s2_q == last_q[7*i +: 7]) begin
                    if (mcnt_q[3*i +: 3] != 3'd7) mcnt_d[3*i +: 3] = mcnt_q[3*i +: 3] + 3'd1;
                end else begin
                    last_d[7*i +: 7] = led_s2_q;
                    mcnt_d[3*i +: 3] = 3'd1;
                end
                if (mcnt_d[3*i +: 3] == STABLE_C) seg_d[7*i +: 7] = led_s2_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_hex
            logic [4:0] dec;
            assign dec               = hex_decode(seg_q[7*gi +: 7]);
            assign hex_d[4*gi +: 4]  = dec[3:0];
            assign hv_d[gi]          = dec[4];
        end
    endgenerate

    always_comb begin
        samp_bit = sample ? ({{(DIGITS-1){1'b0}}, 1'b1} << dig_d) : '0;
        seen_or  = seen_q | samp_bit;
        seen_d   = seen_or;
        frame_d  = 1'b0;
        if (seen_or == '1) begin
            seen_d  = '0;
            frame_d = 1'b1;
        end

        idle_d   = idle_q;
        active_d = active_q;
        if (sample) begin
            idle_d   = '0;
            active_d = 1'b1;
        end else begin
            if (idle_q < TIMEOUT) idle_d = idle_q + 28'd1;
            if (idle_d >= TIMEOUT) active_d = 1'b0;
        end

        ill_d = sel_illegal;
        err_d = err_q;
        if (sel_illegal && !ill_q && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trans_s1_q <= '1;
            trans_s2_q <= '1;
            led_s1_q   <= '1;
            led_s2_q   <= '1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dig_q      <= '0;
            sel_q      <= '1;
            last_q     <= '1;
            mcnt_q     <= '0;
            seg_q      <= '1;
            hex_q      <= '0;
            hv_q       <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
            idle_q     <= '0;
            active_q   <= 1'b0;
            err_q      <= '0;
            ill_q      <= 1'b0;
        end else begin
            trans_s1_q <= trans;
            trans_s2_q <= trans_s1_q;
            led_s1_q   <= led7seg;
            led_s2_q   <= led_s1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            mcnt_q     <= mcnt_d;
            seg_q      <= seg_d;
            hex_q      <= hex_d;
            hv_q       <= hv_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
            err_q      <= err_d;
            ill_q      <= ill_d;
        end
    end

    assign seg_out     = seg_q;
    assign hex_out     = hex_q;
    assign hex_valid   = hv_q;
    assign frame_stb   = frame_q;
    assign scan_active = active_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives scan patterns on the display bus and
// compares the rebuilt patterns, hex decode, frame strobes, error count and timeout.
module tb_seg7_scan_decoder;
    localparam logic [27:0] TMO = 28'd200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  trans;
    logic [6:0]  led7seg;
    logic [48:0] seg_out;
    logic [27:0] hex_out;
    logic [6:0]  hex_valid;
    logic        frame_stb;
    logic        scan_active;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;
    int frame_cnt = 0;

    localparam logic [48:0] SEG_0123456 = {7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000,
                                           7'b0100100, 7'b1111001, 7'b1000000};
    localparam logic [48:0] SEG_0183456 = {7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000,
                                           7'b0000000, 7'b1111001, 7'b1000000};

    seg7_scan_decoder #(.DIGITS(7), .SETTLE(4), .STABLE_SCANS(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .trans(trans), .led7seg(led7seg),
        .seg_out(seg_out), .hex_out(hex_out), .hex_valid(hex_valid),
        .frame_stb(frame_stb), .scan_active(scan_active), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n === 1'b1 && frame_stb === 1'b1) frame_cnt++;

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic show(input int d, input logic [6:0] seg, input int cyc);
        logic [6:0] sel;
        sel = 7'b0000001 << (6 - d);
        trans = ~sel;
        led7seg = seg;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic blank(input int cyc);
        trans = '1;
        led7seg = '1;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] d3seg, input int skip);
        for (int d = 0; d < 7; d++)
            if (d != skip) show(d, (d == 3) ? d3seg : glyph(d), 10);
    endtask

    task automatic test_reset;
        int base;
        rst_n = 1'b0;
        trans = '1;
        led7seg = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (seg_out !== '1) begin errors++; $display("FAIL reset_seg_out got=%h want=%h", seg_out, {49{1'b1}}); end
        checks++; if (hex_out !== '0) begin errors++; $display("FAIL reset_hex_out got=%h want=0", hex_out); end
        checks++; if (hex_valid !== '0) begin errors++; $display("FAIL reset_hex_valid got=%h want=0", hex_valid); end
        checks++; if (frame_stb !== 1'b0) begin errors++; $display("FAIL reset_frame_stb got=%b want=0", frame_stb); end
        checks++; if (scan_active !== 1'b0) begin errors++; $display("FAIL reset_scan_active got=%b want=0", scan_active); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        base = frame_cnt;
        blank(200);
        checks++; if (frame_cnt !== base) begin errors++; $display("FAIL idle_frames got=%0d want=%0d", frame_cnt, base); end
        checks++; if (scan_active !== 1'b0) begin errors++; $display("FAIL idle_scan_active got=%b want=0", scan_active); end
        checks++; if (seg_out !== '1) begin errors++; $display("FAIL idle_seg_out got=%h want=all ones", seg_out); end
        $display("reset + 200 idle cycles: seg_out=%h scan_active=%b", seg_out, scan_active);
    endtask

    task automatic test_scan;
        int base;
        base = frame_cnt;
        frame(glyph(3), -1);
        checks++; if (hex_valid !== 7'h00) begin errors++; $display("FAIL scan_f1_hex_valid got=%h want=00", hex_valid); end
        checks++; if (seg_out !== '1) begin errors++; $display("FAIL scan_f1_seg_out got=%h want=all ones", seg_out); end
        checks++; if (frame_cnt !== base + 1) begin errors++; $display("FAIL scan_f1_frames got=%0d want=%0d", frame_cnt, base + 1); end
        $display("scan frame 1: hex_out=%h hex_valid=%h", hex_out, hex_valid);
        frame(glyph(3), -1);
        checks++; if (hex_out !== 28'h6543210) begin errors++; $display("FAIL scan_f2_hex_out got=%h want=6543210", hex_out); end
        checks++; if (hex_valid !== 7'h7F) begin errors++; $display("FAIL scan_f2_hex_valid got=%h want=7f", hex_valid); end
        checks++; if (seg_out !== SEG_0123456) begin errors++; $display("FAIL scan_f2_seg_out got=%h want=%h", seg_out, SEG_0123456); end
        $display("scan frame 2: hex_out=%h hex_valid=%h", hex_out, hex_valid);
        frame(glyph(3), -1);
        checks++; if (frame_cnt !== base + 3) begin errors++; $display("FAIL scan_f3_frames got=%0d want=%0d", frame_cnt, base + 3); end
        checks++; if (scan_active !== 1'b1) begin errors++; $display("FAIL scan_active got=%b want=1", scan_active); end
        $display("scan frame 3: frames=%0d", frame_cnt - base);
    endtask

    task automatic test_unstable_digit;
        int base;
        logic [6:0] pat;
        base = frame_cnt;
        for (int f = 0; f < 4; f++) begin
            pat = (f % 2 == 0) ? 7'b0011001 : 7'b0110000;
            frame(pat, -1);
            checks++; if (seg_out[27:21] !== 7'b0110000) begin errors++; $display("FAIL flip_f%0d_digit3 got=%b want=0110000", f, seg_out[27:21]); end
            $display("flip frame %0d: digit3 shown=%b committed=%b", f, pat, seg_out[27:21]);
        end
        checks++; if (frame_cnt !== base + 4) begin errors++; $display("FAIL flip_frames got=%0d want=%0d", frame_cnt, base + 4); end
        checks++; if (hex_out !== 28'h6543210) begin errors++; $display("FAIL flip_hex_out got=%h want=6543210", hex_out); end
    endtask

    task automatic test_short_dwell;
        int base;
        blank(4);
        for (int k = 0; k < 3; k++) begin
            show(2, 7'b0000000, 3);
            blank(4);
        end
        checks++; if (hex_out !== 28'h6543210) begin errors++; $display("FAIL short_hex_out got=%h want=6543210", hex_out); end
        base = frame_cnt;
        frame(glyph(3), 2);
        blank(6);
        checks++; if (frame_cnt !== base) begin errors++; $display("FAIL short_seen_bit frames got=%0d want=%0d", frame_cnt, base); end
        $display("short dwell x3 on digit 2: hex_out=%h", hex_out);
        show(2, 7'b0000000, 4);
        blank(4);
        show(2, 7'b0000000, 4);
        blank(6);
        checks++; if (frame_cnt !== base + 1) begin errors++; $display("FAIL settle_edge_frames got=%0d want=%0d", frame_cnt, base + 1); end
        checks++; if (hex_out !== 28'h6543810) begin errors++; $display("FAIL settle_edge_hex_out got=%h want=6543810", hex_out); end
        checks++; if (seg_out !== SEG_0183456) begin errors++; $display("FAIL settle_edge_seg_out got=%h want=%h", seg_out, SEG_0183456); end
        $display("4-cycle dwell x2 on digit 2: hex_out=%h", hex_out);
    endtask

    task automatic test_illegal_select;
        for (int k = 0; k < 3; k++) begin
            trans = 7'b0011111;
            repeat (5) @(negedge clk);
            blank(5);
        end
        blank(3);
        checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL err_cnt_3 got=%0d want=3", err_cnt); end
        $display("3 illegal episodes: err_cnt=%0d", err_cnt);
        for (int k = 0; k < 297; k++) begin
            trans = 7'b0011111;
            repeat (5) @(negedge clk);
            blank(3);
        end
        blank(3);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat got=%0d want=255", err_cnt); end
        checks++; if (hex_out !== 28'h6543810) begin errors++; $display("FAIL err_hex_held got=%h want=6543810", hex_out); end
        $display("300 illegal episodes: err_cnt=%0d", err_cnt);
    endtask

    task automatic test_timeout;
        checks++; if (scan_active !== 1'b0) begin errors++; $display("FAIL tmo_pre_active got=%b want=0", scan_active); end
        show(0, glyph(0), 10);
        checks++; if (scan_active !== 1'b1) begin errors++; $display("FAIL tmo_after_sample got=%b want=1", scan_active); end
        blank(150);
        checks++; if (scan_active !== 1'b1) begin errors++; $display("FAIL tmo_early_fall got=%b want=1", scan_active); end
        blank(100);
        checks++; if (scan_active !== 1'b0) begin errors++; $display("FAIL tmo_fall got=%b want=0", scan_active); end
        checks++; if (hex_out !== 28'h6543810) begin errors++; $display("FAIL tmo_hex_held got=%h want=6543810", hex_out); end
        checks++; if (seg_out !== SEG_0183456) begin errors++; $display("FAIL tmo_seg_held got=%h want=%h", seg_out, SEG_0183456); end
        $display("timeout: scan_active=%b hex_out=%h", scan_active, hex_out);
        show(1, glyph(1), 10);
        checks++; if (scan_active !== 1'b1) begin errors++; $display("FAIL tmo_resume got=%b want=1", scan_active); end
        $display("resume: scan_active=%b", scan_active);
    endtask

    task automatic test_reset_mid_dwell;
        show(4, glyph(4), 2);
        rst_n = 1'b0;
        #1;
        checks++; if (seg_out !== '1) begin errors++; $display("FAIL midrst_seg_out got=%h want=all ones", seg_out); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_err_cnt got=%0d want=0", err_cnt); end
        checks++; if (hex_out !== '0) begin errors++; $display("FAIL midrst_hex_out got=%h want=0", hex_out); end
        @(negedge clk);
        rst_n = 1'b1;
        blank(4);
        show(5, glyph(5), 10);
        blank(6);
        checks++; if (seg_out !== '1) begin errors++; $display("FAIL midrst_match_discard got=%h want=all ones", seg_out); end
        checks++; if (hex_valid !== 7'h00) begin errors++; $display("FAIL midrst_hex_valid got=%h want=00", hex_valid); end
        checks++; if (scan_active !== 1'b1) begin errors++; $display("FAIL midrst_active got=%b want=1", scan_active); end
        $display("reset mid-dwell: seg_out=%h err_cnt=%0d", seg_out, err_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        trans = '1;
        led7seg = '1;
        @(negedge clk);
        test_reset;
        test_scan;
        test_unstable_digit;
        test_short_dwell;
        test_illegal_select;
        test_timeout;
        test_reset_mid_dwell;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Passive monitor on the multiplexed 7-digit display bus: watches `trans` (active-low digit select) and `led7seg` (active-low segments) driven by the effect blocks.
- Reconstructs the per-digit segment patterns, requires them to be stable, and decodes them back to hex nibbles.
- Used for on-board loopback self-test and as a bench checker for display effects.

Parameters:
DIGITS, 7, number of multiplexed digits (fixed 7 for this display)
SETTLE, 4, clk cycles a one-hot select must dwell before segments are sampled (1..15)
STABLE_SCANS, 2, consecutive identical samples of a digit required to commit it (1..7)
TIMEOUT, 28'd100000, clk cycles with no valid sample before the scan is declared dead

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
trans  in  7  digit select, active low; trans[6-i]==0 selects digit i
led7seg  in  7  segments, active low; bit0=a … bit6=g
seg_out  out  49  committed pattern, digit i at [7i+6:7i]
hex_out  out  28  decoded nibble, digit i at [4i+3:4i]
hex_valid  out  7  bit i = committed pattern of digit i is a legal hex glyph
frame_stb  out  1  one-cycle pulse when every digit has been sampled since the last pulse
scan_active  out  1  1 while valid samples arrive within TIMEOUT
err_cnt  out  8  saturating count of illegal selects (more than one bit of trans low)

Behaviour:
- Reset: all outputs and internal state cleared. seg_out=all 1s (blank); hex_out=0; hex_valid=0; frame_stb=0; scan_active=0; err_cnt=0; FSM=IDLE.
- Input handling: trans and led7seg pass through a 2-flop synchroniser. All timing below is in synchronised cycles.
- Select classification:
  - one-hot-low: exactly one bit 0 → valid, digit index d.
  - blank: all 1s.
  - illegal: two or more bits 0 → err_cnt += 1 on the first cycle of each illegal episode, saturating at 255.
- FSM:
  - IDLE: on one-hot select → SETTLE, dwell counter = 1, latch d.
  - SETTLE: select unchanged → count up. When count reaches SETTLE, sample led7seg for digit d → HOLD. Select changes to another one-hot → restart SETTLE with the new d. Blank or illegal → IDLE.
  - HOLD: exactly one sample per dwell. Any select change → IDLE-equivalent handling in the same cycle (a new one-hot goes straight to SETTLE, count=1).
- Stability per digit:
  - Keep last sample and a 3-bit match count.
  - Sample equals last → count += 1, saturating. Otherwise last = sample, count = 1.
  - When count reaches STABLE_SCANS → seg_out[d] = sample; hex decode updated the following cycle (1-cycle latency).
  - A committed digit keeps its value until a different pattern reaches STABLE_SCANS.
- Hex decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern (including blank 1111111 and dash 0111111) → hex=0, hex_valid bit=0.
- Frame:
  - seen mask bit d set on each sample.
  - When the mask becomes all 1s → frame_stb=1 for one cycle and the mask clears. A sample on that same cycle is counted into the new mask.
- Timeout:
  - Idle counter resets on each sample and increments otherwise, saturating.
  - Reaching TIMEOUT → scan_active=0; seg_out and hex_out are held.
  - scan_active=1 on the cycle after any sample.
- Reset mid-dwell: immediate return to reset values; partial dwell and match counts are discarded.

Test Plan:
- Reset then idle 200 cycles → seg_out all 1s, hex_valid=0, scan_active=0, frame_stb never pulses.
- Scan digits 0..6 cyclically, 10 cycles/digit, showing "0123456", for 3 frames → after the 2nd frame hex_out=28'h6543210, hex_valid=7'h7F, frame_stb pulses once per frame.
- Digit 3 flips between 0011001 and 0110000 every frame → seg_out digit 3 never changes from its prior committed value.
- Dwell of only 3 cycles (< SETTLE) on digit 2 → no sample, no seen bit, digit 2 unchanged.
- Drive trans=7'b0011111 for 5 cycles, three separate times → err_cnt=3; with 300 episodes → err_cnt=255.
- Stop scanning (trans all 1s) for TIMEOUT cycles → scan_active falls at cycle TIMEOUT, outputs held; resume → scan_active=1 after the first sample.
